// File: rtl/ifeedback_lock_sequencer_pkg.sv
// Shared definitions for the I-only feedback loop lock sequencer.
// Contents: gain/error widths, control-rail limits, state encoding,
// and small helpers for window detection and saturating counts.
package ifeedback_lock_sequencer_pkg;

  localparam int unsigned GAIN_W = 21;
  localparam int unsigned ERR_W  = 14;
  localparam int unsigned CNT_W  = 32;

  localparam logic signed [ERR_W-1:0] RAIL_HI = 14'sh1FFF;  //  8191
  localparam logic signed [ERR_W-1:0] RAIL_LO = 14'sh2000;  // -8192

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ACQUIRE   = 3'd1,
    ST_LOCKED    = 3'd2,
    ST_RESETTING = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  // Magnitude taken in ERR_W+1 bits so -8192 does not overflow.
  function automatic logic in_window(input logic signed [ERR_W-1:0] err,
                                     input int unsigned window);
    logic signed [ERR_W:0] wide;
    logic [ERR_W:0] mag;
    wide = err;
    mag  = wide[ERR_W] ? unsigned'(-wide) : unsigned'(wide);
    return (CNT_W'(mag) <= window);
  endfunction

  function automatic logic is_railed(input logic signed [ERR_W-1:0] ctl);
    return (ctl == RAIL_HI) || (ctl == RAIL_LO);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/ifeedback_lock_sequencer_gain_ramp_stepper.sv
// gain_ramp_stepper: walks a signed gain toward a target by RAMP_STEP once
// every RAMP_INTERVAL advancing cycles, landing exactly on the target.
// Ports:
//   clock    in   system clock
//   reset    in   synchronous active-high reset (gain 0, interval count 0)
//   clear    in   force gain 0 and restart the interval count
//   advance  in   count this cycle toward the next ramp tick (low = frozen)
//   target   in   signed target gain
//   gain     out  registered signed gain
module gain_ramp_stepper
  import ifeedback_lock_sequencer_pkg::*;
#(
  parameter int unsigned RAMP_STEP     = 64,
  parameter int unsigned RAMP_INTERVAL = 256
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     advance,
  input  logic signed [GAIN_W-1:0] target,
  output logic signed [GAIN_W-1:0] gain
);

  localparam logic signed [GAIN_W:0]   STEP_W = (GAIN_W+1)'(RAMP_STEP);
  localparam logic signed [GAIN_W-1:0] STEP_G = GAIN_W'(RAMP_STEP);
  localparam logic [CNT_W-1:0]         LAST   = CNT_W'(RAMP_INTERVAL - 1);

  logic [CNT_W-1:0]         interval_cnt;
  logic signed [GAIN_W:0]   diff;
  logic signed [GAIN_W-1:0] stepped;

  // Difference in one extra bit; a full step is only taken when it cannot
  // pass the target, otherwise the gain snaps onto the target.
  always_comb begin
    diff = {target[GAIN_W-1], target} - {gain[GAIN_W-1], gain};
    if (diff > STEP_W)
      stepped = gain + STEP_G;
    else if (diff < -STEP_W)
      stepped = gain - STEP_G;
    else
      stepped = target;
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      interval_cnt <= '0;
      gain         <= '0;
    end else if (advance) begin
      if (interval_cnt >= LAST) begin
        interval_cnt <= '0;
        gain         <= stepped;
      end else begin
        interval_cnt <= interval_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ifeedback_lock_sequencer.sv
// ifeedback_lock_sequencer: supervisory controller for one I-only feedback
// loop. Ramps the I gain to the host target, declares lock after a run of
// in-window error, and re-acquires (integrator reset) on loss or railing,
// giving up into FAULT after MAX_RETRIES re-acquires.
// Ports:
//   clock          in   system clock
//   reset          in   synchronous active-high reset
//   enable         in   host loop enable
//   holdRequest    in   freeze integrator and sequencer
//   targetGain     in   signed host target I gain (21b)
//   errorIn        in   signed loop error monitor (14b)
//   controlIn      in   signed loop control output (14b)
//   iGainOut       out  signed gain to loop (21b)
//   intResetOut    out  integrator reset to loop
//   intHoldOut     out  integrator hold to loop
//   lockedOut      out  high in LOCKED
//   faultOut       out  high in FAULT
//   stateOut       out  IDLE=0 ACQUIRE=1 LOCKED=2 RESETTING=3 FAULT=4
//   retryCountOut  out  re-acquires since last IDLE/LOCKED entry
module ifeedback_lock_sequencer
  import ifeedback_lock_sequencer_pkg::*;
#(
  parameter int unsigned RAMP_STEP     = 64,
  parameter int unsigned RAMP_INTERVAL = 256,
  parameter int unsigned LOCK_WINDOW   = 32,
  parameter int unsigned LOCK_COUNT    = 4096,
  parameter int unsigned UNLOCK_COUNT  = 1024,
  parameter int unsigned RAIL_COUNT    = 65536,
  parameter int unsigned RESET_CYCLES  = 64,
  parameter int unsigned MAX_RETRIES   = 7
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     holdRequest,
  input  logic signed [GAIN_W-1:0] targetGain,
  input  logic signed [ERR_W-1:0]  errorIn,
  input  logic signed [ERR_W-1:0]  controlIn,
  output logic signed [GAIN_W-1:0] iGainOut,
  output logic                     intResetOut,
  output logic                     intHoldOut,
  output logic                     lockedOut,
  output logic                     faultOut,
  output logic [2:0]               stateOut,
  output logic [3:0]               retryCountOut
);

  state_t           state, state_d;
  logic [CNT_W-1:0] lock_cnt, lock_d;
  logic [CNT_W-1:0] unlock_cnt, unlock_d;
  logic [CNT_W-1:0] rail_cnt, rail_d;
  logic [CNT_W-1:0] rst_cnt, rst_d;
  logic [3:0]       retry, retry_d;

  logic running, held, in_win, railed, at_target, rail_hit;
  logic running_d, step_clear, step_advance;

  assign running   = (state == ST_ACQUIRE) || (state == ST_LOCKED);
  assign held      = holdRequest && running;
  assign in_win    = in_window(errorIn, LOCK_WINDOW);
  assign railed    = is_railed(controlIn);
  assign at_target = (iGainOut == targetGain);

  always_comb begin
    state_d  = state;
    lock_d   = lock_cnt;
    unlock_d = unlock_cnt;
    rail_d   = rail_cnt;
    rst_d    = rst_cnt;
    retry_d  = retry;
    rail_hit = 1'b0;

    if (running && !held) begin
      rail_d   = railed ? sat_inc(rail_cnt) : '0;
      rail_hit = (rail_d >= RAIL_COUNT);
    end

    unique case (state)
      ST_IDLE: state_d = ST_ACQUIRE;
      ST_ACQUIRE: begin
        if (!held) begin
          lock_d = (in_win && at_target) ? sat_inc(lock_cnt) : '0;
          if (rail_hit)
            state_d = ST_RESETTING;
          else if (lock_d >= LOCK_COUNT)
            state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (!held) begin
          unlock_d = in_win ? '0 : sat_inc(unlock_cnt);
          // Rail and unlock limits share one transition, so one retry.
          if (rail_hit || (unlock_d >= UNLOCK_COUNT))
            state_d = ST_RESETTING;
        end
      end
      ST_RESETTING: begin
        if ((rst_cnt + 1'b1) >= RESET_CYCLES)
          state_d = (retry >= 4'(MAX_RETRIES)) ? ST_FAULT : ST_ACQUIRE;
        else
          rst_d = rst_cnt + 1'b1;
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase

    if (!enable || (targetGain == '0))
      state_d = ST_IDLE;

    if ((state_d == ST_IDLE) || ((state_d == ST_LOCKED) && (state != ST_LOCKED)))
      retry_d = '0;
    else if ((state_d == ST_RESETTING) && (state != ST_RESETTING))
      retry_d = (retry == 4'hF) ? retry : retry + 4'd1;

    // Rail run is allowed to span ACQUIRE<->LOCKED; everything else restarts.
    if (state_d != state) begin
      lock_d   = '0;
      unlock_d = '0;
      rst_d    = '0;
    end
    if ((state_d != ST_ACQUIRE) && (state_d != ST_LOCKED))
      rail_d = '0;
  end

  assign running_d    = (state_d == ST_ACQUIRE) || (state_d == ST_LOCKED);
  assign step_clear   = !running_d;
  assign step_advance = running && !held && running_d;

  gain_ramp_stepper #(
    .RAMP_STEP     (RAMP_STEP),
    .RAMP_INTERVAL (RAMP_INTERVAL)
  ) u_stepper (
    .clock   (clock),
    .reset   (reset),
    .clear   (step_clear),
    .advance (step_advance),
    .target  (targetGain),
    .gain    (iGainOut)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      lock_cnt    <= '0;
      unlock_cnt  <= '0;
      rail_cnt    <= '0;
      rst_cnt     <= '0;
      retry       <= '0;
      intResetOut <= 1'b1;
      intHoldOut  <= 1'b0;
      lockedOut   <= 1'b0;
      faultOut    <= 1'b0;
    end else begin
      state       <= state_d;
      lock_cnt    <= lock_d;
      unlock_cnt  <= unlock_d;
      rail_cnt    <= rail_d;
      rst_cnt     <= rst_d;
      retry       <= retry_d;
      intResetOut <= !running_d;
      intHoldOut  <= holdRequest && running_d;
      lockedOut   <= (state_d == ST_LOCKED);
      faultOut    <= (state_d == ST_FAULT);
    end
  end

  assign stateOut      = state;
  assign retryCountOut = retry;

endmodule
